// File: rtl/stepper_if.sv
// stepper_if: move-command handshake and delay_counter timing channel of the stepper sequencer
interface stepper_if #(parameter int STEPS_W = 16);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [STEPS_W-1:0] cmd_steps;
  logic               cmd_dir;
  logic               cmd_half;
  logic [7:0]         cmd_delay;
  logic               dly_start;
  logic               dly_enable;
  logic [7:0]         dly_delay;
  logic               dly_done;
  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_delay, dly_done,
    input  cmd_ready, dly_start, dly_enable, dly_delay
  );
  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_half, cmd_delay, dly_done,
    output cmd_ready, dly_start, dly_enable, dly_delay
  );
endinterface

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: paces unipolar stepper moves through delay_counter with a linear start ramp
module stepper_sequencer #(
  parameter logic [7:0] RAMP_START = 8'd40,
  parameter int         STEPS_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  stepper_if.slave           bus,
  input  logic               pause,
  input  logic               abort,
  output logic [3:0]         coils,
  output logic               busy,
  output logic               move_done,
  output logic [STEPS_W-1:0] position
);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT, STEP} state_t;
  localparam logic [3:0] PHASE [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                       4'b0100, 4'b1100, 4'b1000, 4'b1001};
  state_t             state, state_n;
  logic [2:0]         idx, idx_n, step_inc;
  logic               energised, energised_n, dir, dir_n, half, half_n, move_done_n, dly_start_q;
  logic [STEPS_W-1:0] remaining, remaining_n, position_n;
  logic [7:0]         cur_delay, cur_delay_n, target, target_n, cmd_target;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      energised   <= 1'b0;
      dir         <= 1'b0;
      half        <= 1'b0;
      remaining   <= '0;
      position    <= '0;
      cur_delay   <= '0;
      target      <= '0;
      move_done   <= 1'b0;
      dly_start_q <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      energised   <= energised_n;
      dir         <= dir_n;
      half        <= half_n;
      remaining   <= remaining_n;
      position    <= position_n;
      cur_delay   <= cur_delay_n;
      target      <= target_n;
      move_done   <= move_done_n;
      dly_start_q <= state_n == LOAD;
    end
  end
  always_comb begin
    cmd_target  = bus.cmd_delay == 8'd0 ? 8'd1 : bus.cmd_delay;
    step_inc    = half ? 3'd1 : 3'd2;
    state_n     = state;
    idx_n       = idx;
    energised_n = energised;
    dir_n       = dir;
    half_n      = half;
    remaining_n = remaining;
    position_n  = position;
    cur_delay_n = cur_delay;
    target_n    = target;
    move_done_n = 1'b0;
    if (abort) begin
      state_n     = IDLE;
      energised_n = 1'b0;
      remaining_n = '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          energised_n = 1'b1;
          remaining_n = bus.cmd_steps;
          dir_n       = bus.cmd_dir;
          half_n      = bus.cmd_half;
          target_n    = cmd_target;
          cur_delay_n = cmd_target > RAMP_START ? cmd_target : RAMP_START;
          // full-step moves run on the two-coil phases (odd indices)
          idx_n       = (!bus.cmd_half && !idx[0]) ? idx + 3'd1 : idx;
          move_done_n = bus.cmd_steps == '0;
          state_n     = bus.cmd_steps == '0 ? IDLE : LOAD;
        end
        LOAD: state_n = ARM;
        // the timer is reloading during ARM, so its done flag is not trusted yet
        ARM:  state_n = WAIT;
        WAIT: state_n = bus.dly_done ? STEP : WAIT;
        STEP: begin
          idx_n       = dir ? idx + step_inc : idx - step_inc;
          position_n  = dir ? position + 1'b1 : position - 1'b1;
          remaining_n = remaining - 1'b1;
          cur_delay_n = cur_delay > target ? cur_delay - 8'd1 : cur_delay;
          move_done_n = remaining == STEPS_W'(1);
          state_n     = remaining == STEPS_W'(1) ? IDLE : LOAD;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  assign bus.cmd_ready  = state == IDLE;
  assign bus.dly_start  = dly_start_q;
  assign bus.dly_enable = ~pause;
  assign bus.dly_delay  = cur_delay;
  assign busy           = state != IDLE;
  assign coils          = energised ? PHASE[idx] : 4'b0000;
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: directed table plus random moves against a step-sequence model, with a delay_counter stand-in
module tb_stepper_sequencer;
  localparam int W = 16;
  localparam logic [3:0] PH [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                    4'b0100, 4'b1100, 4'b1000, 4'b1001};
  logic clk = 1'b0, reset_n = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [3:0] coils;
  logic busy, move_done;
  logic [W-1:0] position;
  stepper_if #(.STEPS_W(W)) bus ();
  stepper_sequencer #(.RAMP_START(8'd40), .STEPS_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .pause(pause), .abort(abort),
    .coils(coils), .busy(busy), .move_done(move_done), .position(position)
  );
  always #5 clk = ~clk;
  // delay_counter stand-in, BASIC_PERIOD=4, done registered so it reads stale right after a start
  logic [9:0] tcnt;
  logic tdone;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt  <= '0;
      tdone <= 1'b0;
    end else begin
      tdone <= tcnt == '0;
      tcnt  <= bus.dly_start ? {bus.dly_delay, 2'b00} : (bus.dly_enable && tcnt != '0) ? tcnt - 1'b1 : tcnt;
    end
  end
  assign bus.dly_done = tdone;
  int n_vec = 0, n_bad = 0;
  int m_idx;
  logic [W-1:0] m_pos;
  bit m_en;
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int dk(input int tgt, input int st, input int k);
    return (st - k) > tgt ? st - k : tgt;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; pause = 1'b0; abort = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_idx = 0; m_pos = '0; m_en = 1'b0;
  endtask
  // kind: 0 plain, 1 pause 20 cycles, 2 abort, 3 reset; applied in WAIT of step ev (0-based)
  task automatic run_move(input int steps, input bit dir, input bit half, input int delay, input int kind, input int ev);
    int inc, tgt, st, k, since, pz, c;
    bit fin, pend, ok_end;
    inc = half ? 1 : 2;
    if (!dir) inc = -inc;
    tgt = delay == 0 ? 1 : delay;
    st = tgt > 40 ? tgt : 40;
    if (!half && m_idx % 2 == 0) m_idx = m_idx + 1;
    m_en = 1'b1;
    @(negedge clk);
    chk("cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_steps = W'(steps); bus.cmd_dir = dir;
    bus.cmd_half = half; bus.cmd_delay = 8'(delay);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (steps == 0) begin
      chk("zero_done", move_done, 1);
      chk("zero_start", bus.dly_start, 0);
      chk("zero_coils", coils, PH[m_idx]);
      @(negedge clk);
      chk("zero_done_pulse", move_done, 0);
      return;
    end
    chk("busy", busy, 1);
    k = 0; since = 0; pz = 0; c = 0; fin = 0; pend = 0; ok_end = 0;
    while (!fin) begin
      if (pz > 0) begin
        pz--;
        if (pz == 19) chk("paused_enable", bus.dly_enable, 0);
        if (pz == 0) pause = 1'b0;
      end
      if (bus.dly_start || move_done) begin
        if (pend) begin
          chk("step_interval", since, 4 * dk(tgt, st, k - 1) + 4 + ((kind == 1 && k - 1 == ev) ? 20 : 0));
          m_idx = (m_idx + 8 + inc) % 8;
          m_pos = dir ? m_pos + 1'b1 : m_pos - 1'b1;
          pend = 0;
        end
        chk("coils", coils, PH[m_idx]);
        if (bus.dly_start) begin
          chk("dly_delay", bus.dly_delay, dk(tgt, st, k));
          k++; pend = 1; since = 0;
        end else begin
          chk("position", position, m_pos);
          chk("step_count", k, steps);
          fin = 1; ok_end = 1;
        end
      end else if (kind != 0 && pend && k - 1 == ev && since == 3) begin
        if (kind == 1) begin
          pause = 1'b1; pz = 20;
        end else begin
          if (kind == 2) abort = 1'b1; else reset_n = 1'b0;
          @(negedge clk);
          abort = 1'b0; reset_n = 1'b1;
          if (kind == 3) begin m_idx = 0; m_pos = '0; end
          m_en = 1'b0;
          chk("halt_busy", busy, 0);
          chk("halt_coils", coils, 0);
          chk("halt_done", move_done, 0);
          chk("halt_start", bus.dly_start, 0);
          chk("halt_position", position, m_pos);
          fin = 1;
        end
      end
      if (!fin) begin
        @(negedge clk);
        since++; c++;
        if (c > 20000) begin
          chk("timeout", c, 0);
          fin = 1;
        end
      end
    end
    if (ok_end) begin
      @(negedge clk);
      chk("done_pulse", move_done, 0);
    end
  endtask
  typedef struct {
    int steps; bit dir; bit half; int delay; int kind; int ev;
    logic [3:0] exp_coils; logic [W-1:0] exp_pos;
  } vec_t;
  vec_t tbl [8];
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_steps = '0; bus.cmd_dir = 1'b0;
    bus.cmd_half = 1'b0; bus.cmd_delay = '0;
    tbl[0] = '{4,  1'b1, 1'b0, 50, 0, -1, 4'b0011, 16'd4};
    tbl[1] = '{3,  1'b0, 1'b1, 38, 0, -1, 4'b1100, 16'hFFFD};
    tbl[2] = '{0,  1'b1, 1'b0, 10, 0, -1, 4'b0011, 16'd0};
    tbl[3] = '{10, 1'b1, 1'b1, 5,  1, 3,  4'b0010, 16'd10};
    tbl[4] = '{8,  1'b1, 1'b0, 2,  2, 2,  4'b0000, 16'd2};
    tbl[5] = '{3,  1'b1, 1'b1, 0,  3, 1,  4'b0000, 16'd0};
    tbl[6] = '{2,  1'b1, 1'b1, 0,  0, -1, 4'b0010, 16'd2};
    tbl[7] = '{3,  1'b0, 1'b0, 60, 0, -1, 4'b0110, 16'hFFFD};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_idx = 0; m_pos = '0; m_en = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_coils", coils, 0);
    chk("rst_position", position, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_start", bus.dly_start, 0);
    chk("rst_done", move_done, 0);
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_move(tbl[i].steps, tbl[i].dir, tbl[i].half, tbl[i].delay, tbl[i].kind, tbl[i].ev);
      @(negedge clk);
      chk("tbl_coils", coils, tbl[i].exp_coils);
      chk("tbl_position", position, tbl[i].exp_pos);
    end
    // abort together with a command: command dropped, coils released, position kept
    run_move(2, 1'b1, 1'b1, 45, 0, -1);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_steps = 16'd5; abort = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; abort = 1'b0; m_en = 1'b0;
    chk("drop_busy", busy, 0);
    chk("drop_coils", coils, 0);
    chk("drop_start", bus.dly_start, 0);
    chk("drop_position", position, m_pos);
    for (int i = 0; i < 24; i++) begin
      int s, ev, kind;
      s = $urandom_range(0, 6);
      kind = (s > 0 && $urandom_range(0, 5) == 0) ? 2 : 0;
      ev = s > 0 ? $urandom_range(0, s - 1) : -1;
      run_move(s, 1'($urandom), 1'($urandom), $urandom_range(0, 50), kind, ev);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rand_coils", coils, m_en ? PH[m_idx] : 0);
      chk("rand_position", position, m_pos);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
